// File: rtl/reg_write_queue.sv
// reg_write_queue: in-order write-request buffer in front of the register
// file write port. Requests enter through a valid/ready handshake and are
// stored in a circular buffer. At most one request per cycle drains onto
// write_enable/rw/busw, unless stall holds it back. Offering a request while
// the queue is full sets a sticky overflow flag and the request is dropped.
module reg_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       stall,
    output logic                       write_enable,
    output logic [AW-1:0]              rw,
    output logic [DW-1:0]              busw,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;

    // Status flags and handshake come from the registered count only, so a
    // pop in the same cycle never opens a slot for a push to a full queue.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        in_ready = !full;
        push     = in_valid && in_ready;
        pop      = !empty && !stall;
    end

    // Head entry drives the write port directly; zero when nothing is queued.
    always_comb begin
        write_enable = pop;
        rw           = '0;
        busw         = '0;
        if (!empty) begin
            rw   = mem[rp].addr;
            busw = mem[rp].data;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= '{addr: in_addr, data: in_data};
    end

    // Pointers, occupancy and sticky overflow; reset wins over push/pop.
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wp <= wp + PW'(1);
            if (pop)
                rp <= rp + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

endmodule
